// File: rtl/fetch_decode_alu_pkg.sv
// Shared constants for the fetch/decode/ALU slice of the MIPS-subset core.
// Holds the ALU operation codes, MIPS primary opcodes and SPECIAL/SPECIAL2
// function codes, the default store geometry, and a sign-extension helper.
package fetch_decode_alu_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h8002_0000;
  localparam int          DEPTH_DEFAULT     = 32'd1024;

  // ALU operation codes driven on alu_opcode
  localparam logic [5:0] ALU_ADD   = 6'd0;
  localparam logic [5:0] ALU_SUB   = 6'd1;
  localparam logic [5:0] ALU_AND   = 6'd2;
  localparam logic [5:0] ALU_OR    = 6'd3;
  localparam logic [5:0] ALU_XOR   = 6'd4;
  localparam logic [5:0] ALU_NOR   = 6'd5;
  localparam logic [5:0] ALU_SLT   = 6'd6;
  localparam logic [5:0] ALU_SLTU  = 6'd7;
  localparam logic [5:0] ALU_SLL   = 6'd8;
  localparam logic [5:0] ALU_SRL   = 6'd9;
  localparam logic [5:0] ALU_SRA   = 6'd10;
  localparam logic [5:0] ALU_PASSB = 6'd11;
  localparam logic [5:0] ALU_MUL   = 6'd12;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SW       = 6'h2B;

  // Function codes (instruction[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  localparam logic [5:0] FN2_MUL = 6'h02;

  function automatic logic [31:0] sign_extend16(input logic [15:0] value);
    return {{16{value[15]}}, value};
  endfunction

endpackage

// File: rtl/fda_alu.sv
// Operand select plus ALU.
// Ports: alu_opcode/alu_src/link_signal (control), rs_val/rt_val/immediate/
// link_address (operand sources), res (result), zero (res == 0).
module fda_alu
  import fetch_decode_alu_pkg::*;
(
  input  logic [5:0]  alu_opcode,
  input  logic        alu_src,
  input  logic        link_signal,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] immediate,
  input  logic [31:0] link_address,
  output logic [31:0] res,
  output logic        zero
);

  logic [31:0] op_a;
  logic [31:0] op_b;

  // Operand selection and ALU evaluation
  always_comb begin
    op_a = rs_val;
    op_b = rt_val;
    res  = 32'd0;
    // Links compute 0 + link_address; shifts take their data from rt.
    if (link_signal) begin
      op_a = 32'd0;
    end else if ((alu_opcode == ALU_SLL) || (alu_opcode == ALU_SRL) || (alu_opcode == ALU_SRA)) begin
      op_a = rt_val;
    end else begin
      op_a = rs_val;
    end
    if (link_signal) begin
      op_b = link_address;
    end else if (alu_src) begin
      op_b = immediate;
    end else begin
      op_b = rt_val;
    end
    case (alu_opcode)
      ALU_ADD:   res = op_a + op_b;
      ALU_SUB:   res = op_a - op_b;
      ALU_AND:   res = op_a & op_b;
      ALU_OR:    res = op_a | op_b;
      ALU_XOR:   res = op_a ^ op_b;
      ALU_NOR:   res = ~(op_a | op_b);
      ALU_SLT:   res = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  res = (op_a < op_b) ? 32'd1 : 32'd0;
      ALU_SLL:   res = op_a << op_b[4:0];
      ALU_SRL:   res = op_a >> op_b[4:0];
      ALU_SRA:   res = $signed(op_a) >>> op_b[4:0];
      ALU_PASSB: res = op_b;
      ALU_MUL:   res = op_a * op_b;
      default:   res = 32'd0;
    endcase
  end

  assign zero = (res == 32'd0);

endmodule

// File: rtl/fda_decoder.sv
// Combinational decode of the fetched word.
// Ports: instruction/instr_pc (fetched word and its pc), rs_val/rt_val (for
// branch compare and jr target); outputs register addresses, immediate,
// alu_opcode, control signals, link_address and jump_target.
module fda_decoder
  import fetch_decode_alu_pkg::*;
(
  input  logic [31:0] instruction,
  input  logic [31:0] instr_pc,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [4:0]  address_s1,
  output logic [4:0]  address_s2,
  output logic [4:0]  address_d,
  output logic [31:0] immediate,
  output logic [5:0]  alu_opcode,
  output logic        alu_src,
  output logic        reg_write,
  output logic        mem_enable,
  output logic        read_write,
  output logic        mem_to_reg,
  output logic        is_byte,
  output logic        branch,
  output logic        jump,
  output logic        link_signal,
  output logic        reg_to_immediate,
  output logic [31:0] link_address,
  output logic [31:0] jump_target
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_sx;
  logic        write_raw;

  assign opcode       = instruction[31:26];
  assign funct        = instruction[5:0];
  assign imm_sx       = sign_extend16(instruction[15:0]);
  assign address_s1   = instruction[25:21];
  assign address_s2   = instruction[20:16];
  assign link_address = instr_pc + 32'd4;

  // Instruction decode; anything unrecognised leaves every enable at 0
  always_comb begin
    address_d        = instruction[20:16];
    immediate        = imm_sx;
    alu_opcode       = ALU_ADD;
    alu_src          = 1'b0;
    write_raw        = 1'b0;
    mem_enable       = 1'b0;
    read_write       = 1'b0;
    mem_to_reg       = 1'b0;
    is_byte          = 1'b0;
    branch           = 1'b0;
    jump             = 1'b0;
    link_signal      = 1'b0;
    reg_to_immediate = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        address_d = instruction[15:11];
        case (funct)
          FN_ADD, FN_ADDU: begin alu_opcode = ALU_ADD;  write_raw = 1'b1; end
          FN_SUB, FN_SUBU: begin alu_opcode = ALU_SUB;  write_raw = 1'b1; end
          FN_AND:          begin alu_opcode = ALU_AND;  write_raw = 1'b1; end
          FN_OR:           begin alu_opcode = ALU_OR;   write_raw = 1'b1; end
          FN_XOR:          begin alu_opcode = ALU_XOR;  write_raw = 1'b1; end
          FN_NOR:          begin alu_opcode = ALU_NOR;  write_raw = 1'b1; end
          FN_SLT:          begin alu_opcode = ALU_SLT;  write_raw = 1'b1; end
          FN_SLTU:         begin alu_opcode = ALU_SLTU; write_raw = 1'b1; end
          FN_SLL, FN_SRL, FN_SRA: begin
            // Shift amount travels through the immediate path.
            alu_opcode = (funct == FN_SLL) ? ALU_SLL : ((funct == FN_SRL) ? ALU_SRL : ALU_SRA);
            immediate  = {27'd0, instruction[10:6]};
            alu_src    = 1'b1;
            write_raw  = 1'b1;
          end
          FN_JR: begin
            jump             = 1'b1;
            reg_to_immediate = 1'b1;
          end
          FN_JALR: begin
            jump             = 1'b1;
            reg_to_immediate = 1'b1;
            link_signal      = 1'b1;
            write_raw        = 1'b1;
          end
          default: write_raw = 1'b0;
        endcase
      end
      OP_SPECIAL2: begin
        address_d = instruction[15:11];
        if (funct == FN2_MUL) begin
          alu_opcode = ALU_MUL;
          write_raw  = 1'b1;
        end else begin
          write_raw  = 1'b0;
        end
      end
      OP_J, OP_JAL: begin
        immediate = {link_address[31:28], instruction[25:0], 2'b00};
        jump      = 1'b1;
        if (opcode == OP_JAL) begin
          address_d   = 5'd31;
          link_signal = 1'b1;
          write_raw   = 1'b1;
        end else begin
          address_d   = 5'd0;
        end
      end
      OP_BEQ, OP_BNE: begin
        immediate  = {imm_sx[29:0], 2'b00};
        alu_opcode = ALU_SUB;
        // Only a taken branch is reported.
        if (opcode == OP_BEQ) begin
          branch = (rs_val == rt_val);
        end else begin
          branch = (rs_val != rt_val);
        end
      end
      OP_ADDI, OP_ADDIU: begin alu_opcode = ALU_ADD;  alu_src = 1'b1; write_raw = 1'b1; end
      OP_SLTI:           begin alu_opcode = ALU_SLT;  alu_src = 1'b1; write_raw = 1'b1; end
      OP_SLTIU:          begin alu_opcode = ALU_SLTU; alu_src = 1'b1; write_raw = 1'b1; end
      OP_ANDI, OP_ORI, OP_XORI: begin
        immediate  = {16'd0, instruction[15:0]};
        alu_opcode = (opcode == OP_ANDI) ? ALU_AND : ((opcode == OP_ORI) ? ALU_OR : ALU_XOR);
        alu_src    = 1'b1;
        write_raw  = 1'b1;
      end
      OP_LUI: begin
        immediate  = {instruction[15:0], 16'd0};
        alu_opcode = ALU_PASSB;
        alu_src    = 1'b1;
        write_raw  = 1'b1;
      end
      OP_LB, OP_LW: begin
        alu_src    = 1'b1;
        mem_enable = 1'b1;
        mem_to_reg = 1'b1;
        write_raw  = 1'b1;
        is_byte    = (opcode == OP_LB);
      end
      OP_SB, OP_SW: begin
        alu_src    = 1'b1;
        mem_enable = 1'b1;
        read_write = 1'b1;
        is_byte    = (opcode == OP_SB);
      end
      default: write_raw = 1'b0;
    endcase
  end

  // Writes to $zero are dropped here so downstream never sees them.
  assign reg_write   = write_raw & (address_d != 5'd0);
  assign jump_target = reg_to_immediate ? rs_val : immediate;

endmodule

// File: rtl/fetch_decode_alu.sv
// Fetch, decode and execute slice of the single-cycle MIPS-subset core.
// Owns the instruction store (preloaded through load_en/load_addr/load_data),
// registers the fetched word and its pc, then decodes and executes it
// combinationally against rs_val/rt_val from the register file.
// Ports: clock/reset, pc, preload port, rs_val/rt_val in; registered
// instruction/instr_pc, decoded fields and controls, link_address,
// jump_target, res and zero out.
module fetch_decode_alu
  import fetch_decode_alu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int          DEPTH     = DEPTH_DEFAULT
)(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic [4:0]  address_s1,
  output logic [4:0]  address_s2,
  output logic [4:0]  address_d,
  output logic [31:0] immediate,
  output logic [5:0]  alu_opcode,
  output logic        alu_src,
  output logic        reg_write,
  output logic        mem_enable,
  output logic        read_write,
  output logic        mem_to_reg,
  output logic        is_byte,
  output logic        branch,
  output logic        jump,
  output logic        link_signal,
  output logic        reg_to_immediate,
  output logic [31:0] link_address,
  output logic [31:0] jump_target,
  output logic [31:0] res,
  output logic        zero
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [31:0] mem [DEPTH];
  logic [31:0] fetch_word;
  logic [31:0] load_word;
  logic        fetch_ok;
  logic        load_ok;

  // Word indices relative to BASE_ADDR; addresses below the base wrap to
  // huge values and so fall out of range naturally.
  assign fetch_word = (pc - BASE_ADDR) >> 2'd2;
  assign load_word  = (load_addr - BASE_ADDR) >> 2'd2;
  assign fetch_ok   = (pc[1:0] == 2'b00) && (fetch_word < DEPTH_W);
  assign load_ok    = (load_word < DEPTH_W);

  // Instruction store preload; contents survive reset
  always_ff @(posedge clock) begin
    if (load_en && load_ok) begin
      mem[load_word[AW-1:0]] <= load_data;
    end
  end

  // Fetch register; a same-edge preload of this word is not yet visible
  always_ff @(posedge clock) begin
    if (reset) begin
      instruction <= 32'd0;
      instr_pc    <= 32'd0;
    end else begin
      instruction <= fetch_ok ? mem[fetch_word[AW-1:0]] : 32'd0;
      instr_pc    <= pc;
    end
  end

  fda_decoder u_decoder (
    .instruction      (instruction),
    .instr_pc         (instr_pc),
    .rs_val           (rs_val),
    .rt_val           (rt_val),
    .address_s1       (address_s1),
    .address_s2       (address_s2),
    .address_d        (address_d),
    .immediate        (immediate),
    .alu_opcode       (alu_opcode),
    .alu_src          (alu_src),
    .reg_write        (reg_write),
    .mem_enable       (mem_enable),
    .read_write       (read_write),
    .mem_to_reg       (mem_to_reg),
    .is_byte          (is_byte),
    .branch           (branch),
    .jump             (jump),
    .link_signal      (link_signal),
    .reg_to_immediate (reg_to_immediate),
    .link_address     (link_address),
    .jump_target      (jump_target)
  );

  fda_alu u_alu (
    .alu_opcode   (alu_opcode),
    .alu_src      (alu_src),
    .link_signal  (link_signal),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .immediate    (immediate),
    .link_address (link_address),
    .res          (res),
    .zero         (zero)
  );

endmodule

// File: tb/tb_fetch_decode_alu.sv
// Scoreboard bench for fetch_decode_alu: a reference model computes the
// architectural outcome of each fetched instruction; a monitor pops and
// compares once per cycle on the falling edge.
module tb_fetch_decode_alu;

  localparam logic [31:0] BASE  = 32'h8002_0000;
  localparam int          DEPTH = 1024;
  localparam int          NPROG = 40;

  localparam logic [5:0] RFN [0:15] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22,
                                        6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01};
  localparam logic [5:0] IOP [0:17] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                                        6'h0F, 6'h20, 6'h23, 6'h28, 6'h2B, 6'h02, 6'h03, 6'h3F, 6'h21};

  logic        clock, reset, load_en;
  logic [31:0] pc, load_addr, load_data, rs_val, rt_val;
  logic [31:0] instruction, instr_pc, immediate, link_address, jump_target, res;
  logic [4:0]  address_s1, address_s2, address_d;
  logic [5:0]  alu_opcode;
  logic        alu_src, reg_write, mem_enable, read_write, mem_to_reg, is_byte;
  logic        branch, jump, link_signal, reg_to_immediate, zero;

  fetch_decode_alu #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .pc(pc), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .rs_val(rs_val), .rt_val(rt_val), .instruction(instruction),
    .instr_pc(instr_pc), .address_s1(address_s1), .address_s2(address_s2),
    .address_d(address_d), .immediate(immediate), .alu_opcode(alu_opcode),
    .alu_src(alu_src), .reg_write(reg_write), .mem_enable(mem_enable),
    .read_write(read_write), .mem_to_reg(mem_to_reg), .is_byte(is_byte),
    .branch(branch), .jump(jump), .link_signal(link_signal),
    .reg_to_immediate(reg_to_immediate), .link_address(link_address),
    .jump_target(jump_target), .res(res), .zero(zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] word, ipc, imm, res, link, jt;
    logic [4:0]  s1, s2, d;
    logic        reg_write, mem_enable, read_write, mem_to_reg, is_byte;
    logic        branch, jump, link_signal, reg_to_immediate, alu_src;
    bit          imm_chk, res_chk, d_chk, src_chk, jt_chk;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem_model [int];
  int          loaded[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (instr_pc %h)", name, act, exp_v, instr_pc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (instr_pc %h)", name, act, exp_v, instr_pc);
    end
  endtask

  // Word index for a byte address, or -1 when outside the store.
  function automatic int word_index(input logic [31:0] a);
    longint unsigned la = a;
    if (la < BASE || la >= BASE + 4 * DEPTH) return -1;
    return int'((la - BASE) / 4);
  endfunction

  function automatic logic [31:0] fetch_model(input logic [31:0] p);
    int idx = word_index(p);
    if (p[1:0] != 2'b00 || idx < 0) return 32'd0;
    return mem_model.exists(idx) ? mem_model[idx] : 32'd0;
  endfunction

  // Architectural meaning of one instruction.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] ipc,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [5:0]  op = w[31:26];
    logic [5:0]  fn = w[5:0];
    logic [4:0]  rt = w[20:16];
    logic [4:0]  rd = w[15:11];
    logic [4:0]  sh = w[10:6];
    logic [31:0] sx = {{16{w[15]}}, w[15:0]};
    logic [31:0] zx = {16'd0, w[15:0]};
    logic        writes = 1'b0;
    logic [4:0]  dst = 5'd0;
    e = '{default: '0};
    e.word = w; e.ipc = ipc; e.link = ipc + 32'd4; e.s1 = w[25:21]; e.s2 = rt;
    case (op)
      6'h00: begin
        dst = rd; e.d_chk = 1; e.src_chk = 1; writes = 1'b1;
        case (fn)
          6'h20, 6'h21: e.res = a + b;
          6'h22, 6'h23: e.res = a - b;
          6'h24: e.res = a & b;
          6'h25: e.res = a | b;
          6'h26: e.res = a ^ b;
          6'h27: e.res = ~(a | b);
          6'h2A: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: e.res = (a < b) ? 32'd1 : 32'd0;
          6'h00, 6'h02, 6'h03: begin
            if (fn == 6'h00) e.res = b << sh;
            else if (fn == 6'h02) e.res = b >> sh;
            else e.res = $signed(b) >>> sh;
            e.imm = {27'd0, sh}; e.imm_chk = 1; e.alu_src = 1'b1;
          end
          6'h08, 6'h09: begin
            e.jump = 1'b1; e.reg_to_immediate = 1'b1; e.jt = a; e.jt_chk = 1; e.src_chk = 0;
            writes = (fn == 6'h09);
            e.link_signal = (fn == 6'h09);
            e.res = ipc + 32'd4;
          end
          default: begin writes = 1'b0; e.d_chk = 0; e.src_chk = 0; end
        endcase
      end
      6'h1C: if (fn == 6'h02) begin
        dst = rd; e.d_chk = 1; writes = 1'b1; e.res = a * b; e.src_chk = 1;
      end
      6'h02, 6'h03: begin
        e.jump = 1'b1;
        e.imm = {e.link[31:28], w[25:0], 2'b00}; e.imm_chk = 1;
        e.jt = e.imm; e.jt_chk = 1;
        if (op == 6'h03) begin
          dst = 5'd31; e.d_chk = 1; writes = 1'b1; e.link_signal = 1'b1; e.res = ipc + 32'd4;
        end
      end
      6'h04, 6'h05: begin
        e.imm = sx << 2; e.imm_chk = 1;
        e.branch = (op == 6'h04) ? (a == b) : (a != b);
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        dst = rt; e.d_chk = 1; writes = 1'b1; e.alu_src = 1'b1; e.src_chk = 1; e.imm_chk = 1;
        e.imm = (op >= 6'h0C && op <= 6'h0E) ? zx : sx;
        case (op)
          6'h0A:   e.res = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0;
          6'h0B:   e.res = (a < sx) ? 32'd1 : 32'd0;
          6'h0C:   e.res = a & zx;
          6'h0D:   e.res = a | zx;
          6'h0E:   e.res = a ^ zx;
          6'h0F:   begin e.res = {w[15:0], 16'd0}; e.imm = e.res; end
          default: e.res = a + sx;
        endcase
      end
      6'h20, 6'h23, 6'h28, 6'h2B: begin
        dst = rt; e.d_chk = 1; e.alu_src = 1'b1; e.src_chk = 1;
        e.imm = sx; e.imm_chk = 1; e.res = a + sx; e.res_chk = 1;
        e.mem_enable = 1'b1; e.is_byte = (op == 6'h20 || op == 6'h28);
        e.read_write = (op == 6'h28 || op == 6'h2B);
        e.mem_to_reg = !e.read_write;
        writes = !e.read_write;
      end
      default: writes = 1'b0;
    endcase
    e.d = dst;
    e.reg_write = writes && (dst != 5'd0);
    if (writes) e.res_chk = 1;
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 9);
    if (k < 4) begin
      w[31:26] = 6'h00; w[5:0] = RFN[$urandom_range(0, 15)];
    end else if (k == 4) begin
      w[31:26] = 6'h1C; w[5:0] = ($urandom_range(0, 3) == 0) ? 6'h03 : 6'h02;
    end else begin
      w[31:26] = IOP[$urandom_range(0, 17)];
    end
    return w;
  endfunction

  // One cycle: present pc (and optional preload), then drive operands and
  // queue the expected outcome of the word fetched at that edge.
  task automatic issue(input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                       input bit ld, input logic [31:0] la, input logic [31:0] ld_d);
    logic [31:0] w;
    int          li;
    pc = p; load_en = ld; load_addr = la; load_data = ld_d;
    @(posedge clock);
    #1;
    load_en = 1'b0;
    w = fetch_model(p);
    li = word_index(la);
    if (ld && li >= 0) begin
      if (!mem_model.exists(li)) loaded.push_back(li);
      mem_model[li] = ld_d;
    end
    rs_val = a; rt_val = b;
    sb_q.push_back(model(w, p, a, b));
  endtask

  // Monitor: compare the presented outputs against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check32("instruction", instruction, e.word);
        check32("instr_pc", instr_pc, e.ipc);
        check32("address_s1", {27'd0, address_s1}, {27'd0, e.s1});
        check32("address_s2", {27'd0, address_s2}, {27'd0, e.s2});
        check32("link_address", link_address, e.link);
        check1("reg_write", reg_write, e.reg_write);
        check1("mem_enable", mem_enable, e.mem_enable);
        check1("read_write", read_write, e.read_write);
        check1("mem_to_reg", mem_to_reg, e.mem_to_reg);
        check1("is_byte", is_byte, e.is_byte);
        check1("branch", branch, e.branch);
        check1("jump", jump, e.jump);
        check1("link_signal", link_signal, e.link_signal);
        check1("reg_to_immediate", reg_to_immediate, e.reg_to_immediate);
        if (e.d_chk)   check32("address_d", {27'd0, address_d}, {27'd0, e.d});
        if (e.imm_chk) check32("immediate", immediate, e.imm);
        if (e.src_chk) check1("alu_src", alu_src, e.alu_src);
        if (e.jt_chk)  check32("jump_target", jump_target, e.jt);
        if (e.res_chk) begin
          check32("res", res, e.res);
          check1("zero", zero, e.res == 32'd0);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [31:0] p, a, b;
    int          guard;
    reset = 1'b1; pc = 32'd0; load_en = 1'b0; load_addr = 32'd0; load_data = 32'd0;
    rs_val = 32'd0; rt_val = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    rs_val = $urandom; rt_val = $urandom;
    sb_q.push_back(model(32'd0, 32'd0, rs_val, rt_val));

    // Directed program
    issue(32'd0, 32'd0, 32'd0, 1'b1, BASE,          32'h2402_0005);
    issue(32'd0, 32'd0, 32'd0, 1'b1, BASE + 32'd4,  32'h0042_1823);
    issue(32'd0, 32'd0, 32'd0, 1'b1, BASE + 32'd8,  32'h8CA4_0008);
    issue(32'd0, 32'd0, 32'd0, 1'b1, BASE + 32'd16, 32'h1022_0003);
    issue(BASE,          32'd0, $urandom, 1'b0, 32'd0, 32'd0);
    issue(BASE + 32'd4,  32'd7, 32'd7,    1'b0, 32'd0, 32'd0);
    issue(BASE + 32'd16, 32'd9, 32'd9,    1'b0, 32'd0, 32'd0);
    issue(BASE + 32'd16, 32'd9, 32'd8,    1'b0, 32'd0, 32'd0);
    issue(BASE + 32'd8,  32'h8003_0000, $urandom, 1'b0, 32'd0, 32'd0);
    issue(32'h8000_0000, $urandom, $urandom, 1'b0, 32'd0, 32'd0);
    // Overwrite the word being fetched: old word must come out first
    issue(BASE, $urandom, $urandom, 1'b1, BASE, 32'h0C00_8004);
    issue(BASE, $urandom, $urandom, 1'b0, 32'd0, 32'd0);
    issue(BASE + 32'd2, $urandom, $urandom, 1'b0, 32'd0, 32'd0);
    // Store edges: last word, one past the end, a load just below the base
    issue(32'd0, 32'd0, 32'd0, 1'b1, BASE + 32'(4 * (DEPTH - 1)), 32'h3C01_1234);
    issue(32'd0, 32'd0, 32'd0, 1'b1, BASE - 32'd4, 32'h2402_0077);
    issue(32'd0, 32'd0, 32'd0, 1'b1, BASE + 32'(4 * DEPTH), 32'h2402_0066);
    issue(BASE + 32'(4 * (DEPTH - 1)), $urandom, $urandom, 1'b0, 32'd0, 32'd0);
    issue(BASE + 32'(4 * DEPTH), $urandom, $urandom, 1'b0, 32'd0, 32'd0);

    // Random program
    for (int i = 0; i < NPROG; i++) begin
      issue(32'd0, 32'd0, 32'd0, 1'b1, BASE + 32'(4 * i), gen_instr());
    end
    for (int i = 0; i < 400; i++) begin
      int k = $urandom_range(0, 19);
      p = BASE + 32'(4 * loaded[$urandom_range(0, loaded.size() - 1)]);
      if (k == 0) p = p + 32'($urandom_range(1, 3));
      else if (k <= 2) p = $urandom;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 4) == 0)
        issue(p, a, b, 1'b1, BASE + 32'(4 * $urandom_range(0, NPROG - 1)), gen_instr());
      else
        issue(p, a, b, 1'b0, 32'd0, 32'd0);
    end

    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
